mem_bus_arbiter: RTL and testbench

- Shares the single memory-mapped I/O bus (RAM, LED, UART, TFT registers) between the Hack CPU and a secondary bus master (DMA/loader port).
- Sits between CPU and MemoryMappedIO in the top level, on CLK_100MHz.
- The CPU keeps absolute priority on its CLK_CPU enable slot. DMA beats run only in the idle gap between CPU slots, using a cycle-phase counter.
- Generates the qualified enable MEM_EN that replaces CLK_CPU at the memory side.

---
 rtl/mem_bus_arbiter_if.sv | 34 +++
 rtl/mem_bus_arbiter.sv | 92 +++++++++
 tb/tb_mem_bus_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - CPU, DMA and memory-side signal bundle for mem_bus_arbiter
interface mem_bus_arbiter_if;
    logic        CLK_CPU;
    logic [15:0] CPU_ADDRESS;
    logic [15:0] CPU_DATA_W;
    logic        CPU_LOAD;
    logic [15:0] CPU_DATA_R;
    logic        DMA_REQ;
    logic [15:0] DMA_ADDRESS;
    logic [15:0] DMA_DATA_W;
    logic        DMA_WE;
    logic        DMA_ACK;
    logic [15:0] DMA_DATA_R;
    logic [15:0] MEM_ADDRESS;
    logic [15:0] MEM_DATA_W;
    logic        MEM_LOAD;
    logic        MEM_EN;
    logic [15:0] MEM_DATA_R;
    logic        OVERRUN;

    modport slave (
        input  CLK_CPU, CPU_ADDRESS, CPU_DATA_W, CPU_LOAD,
        input  DMA_REQ, DMA_ADDRESS, DMA_DATA_W, DMA_WE, MEM_DATA_R,
        output CPU_DATA_R, DMA_ACK, DMA_DATA_R,
        output MEM_ADDRESS, MEM_DATA_W, MEM_LOAD, MEM_EN, OVERRUN
    );

    modport master (
        output CLK_CPU, CPU_ADDRESS, CPU_DATA_W, CPU_LOAD,
        output DMA_REQ, DMA_ADDRESS, DMA_DATA_W, DMA_WE, MEM_DATA_R,
        input  CPU_DATA_R, DMA_ACK, DMA_DATA_R,
        input  MEM_ADDRESS, MEM_DATA_W, MEM_LOAD, MEM_EN, OVERRUN
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - CPU-priority arbiter fitting DMA beats into the gap between CLK_CPU slots
module mem_bus_arbiter #(
    parameter int unsigned DIVISOR = 2000000,
    parameter int unsigned GUARD   = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             CLK_100MHz,
    input  logic             RESET_N,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DMA_ISSUE, DMA_WAIT, DMA_DONE} state_t;

    localparam logic [CNT_W-1:0] PHASE_MAX   = CNT_W'(DIVISOR - 1);
    // Two extra bits so phase+3 can never wrap before the compare.
    localparam logic [CNT_W+1:0] START_LIMIT = (CNT_W+2)'(DIVISOR - GUARD - 1);

    state_t           state;
    logic [CNT_W-1:0] phase;
    logic             synced;
    logic             ack_q;
    logic [15:0]      dma_data_q;
    logic [15:0]      cpu_held;
    logic             overrun_q;

    logic [CNT_W+1:0] phase_plus;
    logic             start_ok;
    logic             cpu_owns;
    logic             dma_drives;

    assign phase_plus = {2'b00, phase} + (CNT_W+2)'(3);
    assign start_ok   = synced && (phase_plus <= START_LIMIT) && !bus.CLK_CPU;
    // A CPU strobe always takes the bus, even mid-beat.
    assign cpu_owns   = (state == IDLE) || bus.CLK_CPU;
    assign dma_drives = ((state == DMA_ISSUE) || (state == DMA_WAIT)) && !bus.CLK_CPU;

    assign bus.MEM_ADDRESS = dma_drives ? bus.DMA_ADDRESS : bus.CPU_ADDRESS;
    assign bus.MEM_DATA_W  = dma_drives ? bus.DMA_DATA_W  : bus.CPU_DATA_W;
    assign bus.MEM_EN      = cpu_owns ? bus.CLK_CPU : (state == DMA_ISSUE);
    assign bus.MEM_LOAD    = cpu_owns ? (bus.CPU_LOAD && bus.CLK_CPU)
                                      : ((state == DMA_ISSUE) && bus.DMA_WE);
    assign bus.CPU_DATA_R  = (state == IDLE) ? bus.MEM_DATA_R : cpu_held;
    assign bus.DMA_ACK     = ack_q && !bus.CLK_CPU;
    assign bus.DMA_DATA_R  = dma_data_q;
    assign bus.OVERRUN     = overrun_q;

    always_ff @(posedge CLK_100MHz) begin
        if (!RESET_N) begin
            state      <= IDLE;
            phase      <= '0;
            synced     <= 1'b0;
            ack_q      <= 1'b0;
            dma_data_q <= '0;
            cpu_held   <= '0;
            overrun_q  <= 1'b0;
        end else begin
            if (bus.CLK_CPU) begin
                phase  <= '0;
                synced <= 1'b1;
            end else if (phase != PHASE_MAX) begin
                phase <= phase + 1'b1;
            end

            ack_q <= 1'b0;
            if (state == IDLE) begin
                cpu_held <= bus.MEM_DATA_R;
            end

            if (bus.CLK_CPU && (state != IDLE)) begin
                state     <= IDLE;
                overrun_q <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.DMA_REQ && start_ok) begin
                            state <= DMA_ISSUE;
                        end
                    end
                    DMA_ISSUE: state <= DMA_WAIT;
                    DMA_WAIT: begin
                        if (!bus.DMA_WE) begin
                            dma_data_q <= bus.MEM_DATA_R;
                        end
                        ack_q <= 1'b1;
                        state <= DMA_DONE;
                    end
                    DMA_DONE: state <= IDLE;
                    default:  state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter with a registered memory model
module tb_mem_bus_arbiter;
    logic        clk;
    logic        resetn;
    logic [15:0] mem [0:65535];
    logic [15:0] mem_rd;
    logic [15:0] sb [$];
    int          checks;
    int          passed;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.DIVISOR(20), .GUARD(4), .CNT_W(32)) dut (
        .CLK_100MHz(clk),
        .RESET_N   (resetn),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.MEM_EN && bus.MEM_LOAD) mem[bus.MEM_ADDRESS] <= bus.MEM_DATA_W;
        mem_rd <= mem[bus.MEM_ADDRESS];
    end
    assign bus.MEM_DATA_R = mem_rd;

    task automatic cpu_pulse();
        @(negedge clk);
        bus.CLK_CPU = 1'b1;
        @(negedge clk);
        bus.CLK_CPU = 1'b0;
    endtask

    task automatic wait_ack(output int lat, output int en_cnt, output logic [15:0] en_addr,
                            output logic [15:0] en_dw, output logic en_load, output logic [15:0] rdata);
        bit got;
        got = 0; lat = 0; en_cnt = 0; en_addr = 'x; en_dw = 'x; en_load = 1'bx; rdata = 'x;
        for (int c = 1; c <= 30 && !got; c++) begin
            @(negedge clk); #1;
            if (bus.MEM_EN && !bus.CLK_CPU) begin
                en_cnt++;
                en_addr = bus.MEM_ADDRESS; en_dw = bus.MEM_DATA_W; en_load = bus.MEM_LOAD;
            end
            if (bus.DMA_ACK) begin
                got = 1; lat = c; rdata = bus.DMA_DATA_R; bus.DMA_REQ = 1'b0;
            end
        end
        bus.DMA_REQ = 1'b0;
    endtask

    task automatic test_reset();
        int seen;
        resetn = 1'b0;
        bus.DMA_REQ = 1'b1; bus.DMA_ADDRESS = 16'h4000; bus.DMA_WE = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.MEM_EN !== 1'b0) $display("FAIL reset_mem_en: got %b expected 0", bus.MEM_EN); else passed++;
        checks++; if (bus.OVERRUN !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", bus.OVERRUN); else passed++;
        checks++; if (bus.DMA_DATA_R !== 16'h0000) $display("FAIL reset_dma_data: got %h expected 0000", bus.DMA_DATA_R); else passed++;
        resetn = 1'b1;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); #1;
            if (bus.DMA_ACK || bus.MEM_EN) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL unsynced_block: got %0d active cycles expected 0", seen); else passed++;
        bus.DMA_REQ = 1'b0;
    endtask

    task automatic test_dma_read();
        int lat, en_cnt;
        logic [15:0] en_addr, en_dw, rdata, exp;
        logic en_load;
        cpu_pulse();
        repeat (2) @(negedge clk);
        bus.DMA_ADDRESS = 16'h4000; bus.DMA_WE = 1'b0; bus.DMA_REQ = 1'b1;
        sb.push_back(16'h1234);
        wait_ack(lat, en_cnt, en_addr, en_dw, en_load, rdata);
        exp = sb.pop_front();
        checks++; if (lat !== 3) $display("FAIL read_latency: got %0d expected 3", lat); else passed++;
        checks++; if (en_cnt !== 1) $display("FAIL read_en_count: got %0d expected 1", en_cnt); else passed++;
        checks++; if (en_addr !== 16'h4000) $display("FAIL read_addr: got %h expected 4000", en_addr); else passed++;
        checks++; if (en_load !== 1'b0) $display("FAIL read_load: got %b expected 0", en_load); else passed++;
        checks++; if (rdata !== exp) $display("FAIL read_data: got %h expected %h", rdata, exp); else passed++;
        @(negedge clk); #1;
        checks++; if (bus.DMA_ACK !== 1'b0) $display("FAIL ack_single: got %b expected 0", bus.DMA_ACK); else passed++;
        checks++; if (bus.DMA_DATA_R !== exp) $display("FAIL read_hold: got %h expected %h", bus.DMA_DATA_R, exp); else passed++;
    endtask

    task automatic test_dma_write();
        int lat, en_cnt;
        logic [15:0] en_addr, en_dw, rdata;
        logic en_load;
        bus.DMA_ADDRESS = 16'h0010; bus.DMA_DATA_W = 16'h00AA; bus.DMA_WE = 1'b1; bus.DMA_REQ = 1'b1;
        wait_ack(lat, en_cnt, en_addr, en_dw, en_load, rdata);
        checks++; if (lat !== 3) $display("FAIL write_latency: got %0d expected 3", lat); else passed++;
        checks++; if (en_cnt !== 1) $display("FAIL write_en_count: got %0d expected 1", en_cnt); else passed++;
        checks++; if (en_load !== 1'b1) $display("FAIL write_load: got %b expected 1", en_load); else passed++;
        checks++; if (en_addr !== 16'h0010) $display("FAIL write_addr: got %h expected 0010", en_addr); else passed++;
        checks++; if (en_dw !== 16'h00AA) $display("FAIL write_data: got %h expected 00aa", en_dw); else passed++;
        checks++; if (mem[16'h0010] !== 16'h00AA) $display("FAIL write_mem: got %h expected 00aa", mem[16'h0010]); else passed++;
        bus.DMA_WE = 1'b0;
    endtask

    task automatic test_guard();
        int lat, en_cnt, seen;
        logic [15:0] en_addr, en_dw, rdata, exp;
        logic en_load;
        cpu_pulse();
        repeat (13) @(negedge clk);
        bus.DMA_ADDRESS = 16'h4001; bus.DMA_WE = 1'b0; bus.DMA_REQ = 1'b1;
        sb.push_back(16'h4001 ^ 16'h5A5A);
        seen = 0;
        #1; if (bus.MEM_EN || bus.DMA_ACK) seen++;
        for (int c = 14; c <= 18; c++) begin
            @(negedge clk); #1;
            if (bus.MEM_EN || bus.DMA_ACK) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL guard_quiet: got %0d active cycles expected 0", seen); else passed++;
        @(negedge clk);
        bus.CLK_CPU = 1'b1; bus.CPU_ADDRESS = 16'h2222; bus.CPU_LOAD = 1'b0;
        #1;
        checks++; if (bus.MEM_ADDRESS !== 16'h2222) $display("FAIL guard_cpu_addr: got %h expected 2222", bus.MEM_ADDRESS); else passed++;
        checks++; if (bus.MEM_EN !== 1'b1) $display("FAIL guard_cpu_en: got %b expected 1", bus.MEM_EN); else passed++;
        @(negedge clk);
        bus.CLK_CPU = 1'b0;
        wait_ack(lat, en_cnt, en_addr, en_dw, en_load, rdata);
        exp = sb.pop_front();
        checks++; if (lat !== 3) $display("FAIL guard_start_latency: got %0d expected 3", lat); else passed++;
        checks++; if (en_addr !== 16'h4001) $display("FAIL guard_dma_addr: got %h expected 4001", en_addr); else passed++;
        checks++; if (rdata !== exp) $display("FAIL guard_data: got %h expected %h", rdata, exp); else passed++;
    endtask

    task automatic test_back_to_back();
        int ph, win, acks, last_c, last_win, bad;
        bit pulse_prev;
        logic [15:0] a, exp;
        cpu_pulse();
        ph = 0; win = 0; acks = 0; last_c = 0; last_win = -1; bad = 0; pulse_prev = 0;
        a = 16'h4100;
        bus.DMA_WE = 1'b0; bus.DMA_ADDRESS = a; bus.DMA_REQ = 1'b1;
        sb.push_back(a ^ 16'h5A5A);
        for (int c = 1; c <= 120 && acks < 8; c++) begin
            @(negedge clk);
            if (pulse_prev) begin ph = 0; win++; end else ph++;
            bus.CLK_CPU = (ph == 19);
            pulse_prev = bus.CLK_CPU;
            #1;
            if (bus.MEM_EN && !bus.CLK_CPU && ph > 13) bad++;
            if (bus.DMA_ACK) begin
                if (ph > 15) bad++;
                exp = sb.pop_front();
                checks++; if (bus.DMA_DATA_R !== exp) $display("FAIL b2b_data: got %h expected %h", bus.DMA_DATA_R, exp); else passed++;
                if (last_win == win) begin
                    checks++; if (c - last_c !== 4) $display("FAIL b2b_period: got %0d expected 4", c - last_c); else passed++;
                end
                last_win = win; last_c = c; acks++;
                a = a + 16'h0001;
                if (acks < 8) begin
                    bus.DMA_ADDRESS = a;
                    sb.push_back(a ^ 16'h5A5A);
                end else begin
                    bus.DMA_REQ = 1'b0;
                end
            end
        end
        bus.CLK_CPU = 1'b0; bus.DMA_REQ = 1'b0;
        checks++; if (acks !== 8) $display("FAIL b2b_count: got %0d expected 8", acks); else passed++;
        checks++; if (bad !== 0) $display("FAIL b2b_guard: got %0d guard hits expected 0", bad); else passed++;
    endtask

    task automatic test_overrun();
        int seen;
        cpu_pulse();
        bus.DMA_ADDRESS = 16'h4002; bus.DMA_WE = 1'b0; bus.DMA_REQ = 1'b1;
        repeat (2) @(negedge clk);
        bus.CLK_CPU = 1'b1; bus.CPU_ADDRESS = 16'h3333; bus.CPU_DATA_W = 16'h5555; bus.CPU_LOAD = 1'b1;
        #1;
        checks++; if (bus.MEM_EN !== 1'b1) $display("FAIL ovr_cpu_en: got %b expected 1", bus.MEM_EN); else passed++;
        checks++; if (bus.MEM_ADDRESS !== 16'h3333) $display("FAIL ovr_cpu_addr: got %h expected 3333", bus.MEM_ADDRESS); else passed++;
        checks++; if (bus.MEM_LOAD !== 1'b1) $display("FAIL ovr_cpu_load: got %b expected 1", bus.MEM_LOAD); else passed++;
        seen = 0;
        if (bus.DMA_ACK) seen++;
        @(negedge clk);
        bus.CLK_CPU = 1'b0; bus.CPU_LOAD = 1'b0; bus.DMA_REQ = 1'b0;
        #1;
        checks++; if (bus.OVERRUN !== 1'b1) $display("FAIL ovr_flag: got %b expected 1", bus.OVERRUN); else passed++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (bus.DMA_ACK) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL ovr_no_ack: got %0d acks expected 0", seen); else passed++;
        checks++; if (bus.OVERRUN !== 1'b1) $display("FAIL ovr_sticky: got %b expected 1", bus.OVERRUN); else passed++;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++; if (bus.OVERRUN !== 1'b0) $display("FAIL ovr_reset_clear: got %b expected 0", bus.OVERRUN); else passed++;
        checks++; if (bus.DMA_DATA_R !== 16'h0000) $display("FAIL ovr_reset_data: got %h expected 0000", bus.DMA_DATA_R); else passed++;
    endtask

    initial begin
        checks = 0; passed = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
        mem[16'h4000] = 16'h1234;
        bus.CLK_CPU = 1'b0; bus.CPU_ADDRESS = 16'h0000; bus.CPU_DATA_W = 16'h0000; bus.CPU_LOAD = 1'b0;
        bus.DMA_REQ = 1'b0; bus.DMA_ADDRESS = 16'h0000; bus.DMA_DATA_W = 16'h0000; bus.DMA_WE = 1'b0;
        resetn = 1'b0;
        test_reset();
        test_dma_read();
        test_dma_write();
        test_guard();
        test_back_to_back();
        test_overrun();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
